// File: rtl/q2_ctrl_if.sv
// Bus bundle between the q2 block controller and its surroundings:
// start/status handshake, source and reciprocal read ports, quantizer
// operand/result lanes and the destination write port.
// Optional macro: Q2_CTRL_ZCNT_EN adds the zero-half counter zcnt_o.
interface q2_ctrl_if #(
  parameter int AW = 5
);
  logic          start_i;
  logic          hold_i;
  logic          busy_o;
  logic          done_o;
  logic          src_rd_o;
  logic [AW-1:0] src_addr_o;
  logic [31:0]   src_data_i;
  logic [AW-1:0] rec_addr_o;
  logic [31:0]   rec_data_i;
  logic [31:0]   q_x_o;
  logic [31:0]   q_rec_o;
  logic [31:0]   q_res_i;
  logic          dst_wr_o;
  logic [AW-1:0] dst_addr_o;
  logic [31:0]   dst_data_o;
`ifdef Q2_CTRL_ZCNT_EN
  logic [6:0]    zcnt_o;
`endif

  // Controller side: drives strobes, addresses and operands.
  modport master (
    input  start_i, hold_i, src_data_i, rec_data_i, q_res_i,
    output busy_o, done_o, src_rd_o, src_addr_o, rec_addr_o,
    output q_x_o, q_rec_o, dst_wr_o, dst_addr_o, dst_data_o
`ifdef Q2_CTRL_ZCNT_EN
    , output zcnt_o
`endif
  );

  // Environment side: buffers, quantizer and the Wishbone control logic.
  modport slave (
    output start_i, hold_i, src_data_i, rec_data_i, q_res_i,
    input  busy_o, done_o, src_rd_o, src_addr_o, rec_addr_o,
    input  q_x_o, q_rec_o, dst_wr_o, dst_addr_o, dst_data_o
`ifdef Q2_CTRL_ZCNT_EN
    , input zcnt_o
`endif
  );
endinterface

// File: rtl/q2_ctrl.sv
// q2_ctrl: walks one 8x8 block (NWORDS packed coefficient pairs) through the
// two-lane quantizer. Read at cycle t, operands presented at t+1, result
// written at t+2. The pipeline never stalls; hold_i only inserts bubbles.
// Optional macro: Q2_CTRL_ZCNT_EN adds zcnt_o, the number of all-zero 16-bit
// result halves written during the current block.
module q2_ctrl #(
  parameter int NWORDS = 32,
  parameter int AW     = 5
) (
  input logic        clk_i,
  input logic        rst_i,
  q2_ctrl_if.master  bus
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t        r_state;
  logic [AW-1:0] r_rdCnt;
  logic          r_v1;
  logic [AW-1:0] r_a1;
  logic          r_wr;
  logic [AW-1:0] r_dstAddr;
  logic [31:0]   r_dstData;

  logic          w_rdIssue;
  logic          w_lastRd;
  logic          w_startOk;

  assign w_rdIssue = (r_state == RUN) && !bus.hold_i;
  assign w_lastRd  = w_rdIssue && (r_rdCnt == AW'(NWORDS - 1));
  assign w_startOk = (r_state == IDLE) && bus.start_i;

  // Block sequencer: accepts start, issues NWORDS reads, drains, pulses done.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_rdCnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start_i) begin
            r_state <= RUN;
            r_rdCnt <= '0;
          end
        end
        RUN: begin
          if (w_rdIssue) begin
            if (w_lastRd) begin
              r_rdCnt <= '0;
              r_state <= FLUSH;
            end else begin
              r_rdCnt <= r_rdCnt + AW'(1);
            end
          end
        end
        FLUSH: begin
          if (!r_v1 && !r_wr) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Valid-tagged data path: tag the read, then capture the quantizer result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_v1      <= 1'b0;
      r_a1      <= '0;
      r_wr      <= 1'b0;
      r_dstAddr <= '0;
      r_dstData <= '0;
    end else begin
      r_v1 <= w_rdIssue;
      if (w_rdIssue) begin
        r_a1 <= r_rdCnt;
      end
      r_wr <= r_v1;
      if (r_v1) begin
        r_dstAddr <= r_a1;
        r_dstData <= bus.q_res_i;
      end
    end
  end

  assign bus.busy_o     = (r_state == RUN) || (r_state == FLUSH);
  assign bus.done_o     = (r_state == DONE);
  assign bus.src_rd_o   = w_rdIssue;
  assign bus.src_addr_o = r_rdCnt;
  assign bus.rec_addr_o = r_rdCnt;
  assign bus.q_x_o      = r_v1 ? bus.src_data_i : 32'd0;
  assign bus.q_rec_o    = r_v1 ? bus.rec_data_i : 32'd0;
  assign bus.dst_wr_o   = r_wr;
  assign bus.dst_addr_o = r_dstAddr;
  assign bus.dst_data_o = r_dstData;

`ifdef Q2_CTRL_ZCNT_EN
  logic [6:0] r_zcnt;
  logic [1:0] w_zInc;

  assign w_zInc = {1'b0, (r_dstData[31:16] == 16'd0)} +
                  {1'b0, (r_dstData[15:0]  == 16'd0)};

  // Zero-half tally: cleared on an accepted start, bumped on every write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_zcnt <= '0;
    end else if (w_startOk) begin
      r_zcnt <= '0;
    end else if (r_wr) begin
      r_zcnt <= r_zcnt + {5'd0, w_zInc};
    end
  end

  assign bus.zcnt_o = r_zcnt;
`else
  logic w_unusedStart;
  assign w_unusedStart = w_startOk;
`endif

endmodule

// File: tb/tb_q2_ctrl.sv
// Self-checking bench for q2_ctrl: table of block scenarios (holds, extra
// starts, data patterns, hand-computed done cycle) plus hand-written reset
// and zero-counter sequences.
module tb_q2_ctrl;
  localparam int NWORDS = 32;
  localparam int AW     = 5;

  typedef struct {
    int holdStart;
    int holdLen;
    int xStart1;
    int xStart2;
    int pattern;
    int expDone;
  } vec_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] srcMem [NWORDS];
  logic [31:0] recMem [NWORDS];

  q2_ctrl_if #(.AW(AW)) bus();

  q2_ctrl #(.NWORDS(NWORDS), .AW(AW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // Buffer model: one-cycle read latency for source and reciprocal RAMs.
  always @(posedge clk_i) begin
    if (bus.src_rd_o) begin
      bus.src_data_i <= srcMem[bus.src_addr_o];
      bus.rec_data_i <= recMem[bus.rec_addr_o];
    end
  end

  // Quantizer lane: sign-magnitude, (|x|*rec + 2^16) >> 17.
  function automatic logic [15:0] qLane(input logic [15:0] x, input logic [15:0] r);
    logic [15:0] mag;
    logic [15:0] q;
    logic [32:0] p;
    mag = x[15] ? (~x + 16'd1) : x;
    p   = {17'd0, mag} * {17'd0, r} + 33'h10000;
    q   = p[32:17];
    return x[15] ? (~q + 16'd1) : q;
  endfunction

  function automatic logic [31:0] qPair(input logic [31:0] a, input logic [31:0] b);
    return {qLane(a[31:16], b[31:16]), qLane(a[15:0], b[15:0])};
  endfunction

  assign bus.q_res_i = qPair(bus.q_x_o, bus.q_rec_o);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic loadPattern(input int p);
    for (int k = 0; k < NWORDS; k++) begin
      case (p)
        0: begin srcMem[k] = 32'h0064FF9C; recMem[k] = 32'h08000800; end
        1: begin
          srcMem[k] = {16'(k * 1000 - 9000), 16'(5 + k * 37)};
          recMem[k] = {16'(1024 + k * 273), 16'(8192 - k * 80)};
        end
        2: begin srcMem[k] = 32'h00000005; recMem[k] = 32'h00010001; end
        default: begin srcMem[k] = 32'h7FFF7FFF; recMem[k] = 32'h08000800; end
      endcase
    end
  endtask

  // Runs one block from cycle 0 (start) to expDone+3; entered just after a posedge.
  task automatic applyStimulus(input vec_t v);
    int   expIdx;
    int   wrCnt;
    int   doneCnt;
    logic expRd;
    logic rdP1, rdP2;
    int   idxP1, idxP2;
    expIdx = 0; wrCnt = 0; doneCnt = 0;
    rdP1 = 1'b0; rdP2 = 1'b0; idxP1 = 0; idxP2 = 0;
    loadPattern(v.pattern);
    for (int c = 0; c <= v.expDone + 3; c++) begin
      bus.start_i = (c == 0) || (c == v.xStart1) || (c == v.xStart2);
      bus.hold_i  = (c >= v.holdStart) && (c < v.holdStart + v.holdLen);
      expRd = (c >= 1) && !bus.hold_i && (expIdx < NWORDS);
      @(negedge clk_i);
      checkOutput($sformatf("busy c=%0d", c), {31'd0, bus.busy_o},
                  {31'd0, (c >= 1) && (c < v.expDone)});
      checkOutput($sformatf("done c=%0d", c), {31'd0, bus.done_o}, {31'd0, c == v.expDone});
      checkOutput($sformatf("src_rd c=%0d", c), {31'd0, bus.src_rd_o}, {31'd0, expRd});
      if (expRd) begin
        checkOutput($sformatf("src_addr c=%0d", c), {27'd0, bus.src_addr_o}, 32'(expIdx));
        checkOutput($sformatf("rec_addr c=%0d", c), {27'd0, bus.rec_addr_o}, 32'(expIdx));
      end
      checkOutput($sformatf("q_x c=%0d", c), bus.q_x_o, rdP1 ? srcMem[idxP1] : 32'd0);
      checkOutput($sformatf("q_rec c=%0d", c), bus.q_rec_o, rdP1 ? recMem[idxP1] : 32'd0);
      checkOutput($sformatf("dst_wr c=%0d", c), {31'd0, bus.dst_wr_o}, {31'd0, rdP2});
      if (rdP2) begin
        checkOutput($sformatf("dst_addr c=%0d", c), {27'd0, bus.dst_addr_o}, 32'(idxP2));
        checkOutput($sformatf("dst_data c=%0d", c), bus.dst_data_o,
                    qPair(srcMem[idxP2], recMem[idxP2]));
        if (v.pattern == 0) begin
          checkOutput($sformatf("dst_const c=%0d", c), bus.dst_data_o, 32'h0002FFFE);
        end
      end
      if (bus.dst_wr_o) wrCnt++;
      if (bus.done_o) doneCnt++;
      rdP2 = rdP1; idxP2 = idxP1;
      rdP1 = expRd; idxP1 = expIdx;
      if (expRd) expIdx++;
      @(posedge clk_i);
      #1;
    end
    bus.start_i = 1'b0;
    bus.hold_i  = 1'b0;
    checkOutput("write count", 32'(wrCnt), 32'd32);
    checkOutput("done count", 32'(doneCnt), 32'd1);
  endtask

  vec_t vecs [6];

  initial begin
    int wrSeen;
    int doneSeen;
    vec_t zv;

    vecs[0] = '{holdStart: -10, holdLen: 0, xStart1: -1, xStart2: -1, pattern: 0, expDone: 36};
    vecs[1] = '{holdStart: 10,  holdLen: 3, xStart1: -1, xStart2: -1, pattern: 1, expDone: 39};
    vecs[2] = '{holdStart: -10, holdLen: 0, xStart1: 5,  xStart2: 36, pattern: 1, expDone: 36};
    vecs[3] = '{holdStart: 33,  holdLen: 3, xStart1: -1, xStart2: -1, pattern: 1, expDone: 36};
    vecs[4] = '{holdStart: 1,   holdLen: 2, xStart1: -1, xStart2: -1, pattern: 0, expDone: 38};
    vecs[5] = '{holdStart: 0,   holdLen: 1, xStart1: -1, xStart2: -1, pattern: 1, expDone: 36};

    bus.start_i = 1'b0;
    bus.hold_i  = 1'b0;
    loadPattern(0);

    // Reset state.
    #23;
    checkOutput("reset busy", {31'd0, bus.busy_o}, 32'd0);
    checkOutput("reset done", {31'd0, bus.done_o}, 32'd0);
    checkOutput("reset src_rd", {31'd0, bus.src_rd_o}, 32'd0);
    checkOutput("reset dst_wr", {31'd0, bus.dst_wr_o}, 32'd0);
    checkOutput("reset src_addr", {27'd0, bus.src_addr_o}, 32'd0);
    checkOutput("reset dst_addr", {27'd0, bus.dst_addr_o}, 32'd0);
    checkOutput("reset dst_data", bus.dst_data_o, 32'd0);
    checkOutput("reset q_x", bus.q_x_o, 32'd0);
`ifdef Q2_CTRL_ZCNT_EN
    checkOutput("reset zcnt", {25'd0, bus.zcnt_o}, 32'd0);
`endif
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
    end

    // Reset in the middle of RUN abandons the block.
    loadPattern(1);
    bus.start_i = 1'b1;
    @(posedge clk_i);
    #1;
    bus.start_i = 1'b0;
    repeat (9) begin
      @(posedge clk_i);
      #1;
    end
    rst_i = 1'b1;
    #1;
    checkOutput("midrst busy", {31'd0, bus.busy_o}, 32'd0);
    checkOutput("midrst src_rd", {31'd0, bus.src_rd_o}, 32'd0);
    checkOutput("midrst src_addr", {27'd0, bus.src_addr_o}, 32'd0);
    checkOutput("midrst dst_wr", {31'd0, bus.dst_wr_o}, 32'd0);
    checkOutput("midrst dst_addr", {27'd0, bus.dst_addr_o}, 32'd0);
    checkOutput("midrst dst_data", bus.dst_data_o, 32'd0);
    checkOutput("midrst q_x", bus.q_x_o, 32'd0);
    checkOutput("midrst q_rec", bus.q_rec_o, 32'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    wrSeen = 0;
    doneSeen = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (bus.dst_wr_o) wrSeen++;
      if (bus.done_o) doneSeen++;
    end
    checkOutput("post-reset writes", 32'(wrSeen), 32'd0);
    checkOutput("post-reset done", 32'(doneSeen), 32'd0);
    @(posedge clk_i);
    #1;
    applyStimulus(vecs[0]);

`ifdef Q2_CTRL_ZCNT_EN
    // Zero counter: all-zero results, then no zero results.
    zv = '{holdStart: -10, holdLen: 0, xStart1: -1, xStart2: -1, pattern: 2, expDone: 36};
    applyStimulus(zv);
    checkOutput("zcnt all zero", {25'd0, bus.zcnt_o}, 32'd64);
    zv.pattern = 3;
    applyStimulus(zv);
    checkOutput("zcnt none zero", {25'd0, bus.zcnt_o}, 32'd0);
`else
    zv = vecs[0];
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
